// File: rtl/counter_enable_gen.sv
// counter_enable_gen: turns start/stop/hold commands into a prescaled train of
// one-cycle enable pulses for a downstream up-counter. Runs either a burst of
// burst_len pulses or free-runs (burst_len == 0) until stopped.
module counter_enable_gen #(
  parameter int DIV_WIDTH = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] pulses_left
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_q_nxt;
  logic                 enable_nxt, busy_nxt, done_nxt;
  logic [LEN_WIDTH-1:0] left_nxt;
  logic                 at_div;
  logic                 last_pulse;
  logic                 free_run;

  assign at_div     = (cnt == div_q);
  assign last_pulse = (pulses_left == LEN_WIDTH'(1));
  // A burst run leaves RUN on the edge its count reaches zero, so a zero
  // count while running can only mean the run was latched as free-run.
  assign free_run   = (pulses_left == '0);

  // State and all outputs are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      div_q       <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      div_q       <= div_q_nxt;
      enable      <= enable_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pulses_left <= left_nxt;
    end
  end

  // Next-state / next-output decode; stop beats hold beats pulse issue.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    div_q_nxt  = div_q;
    enable_nxt = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = busy;
    left_nxt   = pulses_left;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          div_q_nxt = div;
          left_nxt  = burst_len;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          left_nxt  = '0;
        end else if (hold) begin
          state_nxt = PAUSE;
        end else if (at_div) begin
          enable_nxt = 1'b1;
          cnt_nxt    = '0;
          if (last_pulse) begin
            left_nxt  = '0;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else if (!free_run) begin
            left_nxt = pulses_left - 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          left_nxt  = '0;
        end else if (!hold) begin
          // The resume edge still counts toward the period, so a hold of N
          // cycles delays the next pulse by exactly N. A pulse is never
          // issued here; if already at the terminal count it fires next edge.
          state_nxt = RUN;
          if (!at_div) cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        left_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_enable_gen.sv
// Bench for counter_enable_gen: directed vector table, hand-written hold and
// free-run sequences, then random stimulus against a countdown-style model.
module tb_counter_enable_gen;

  logic       clock = 1'b0;
  logic       reset, start, stop, hold;
  logic [3:0] div;
  logic [7:0] burst_len;
  logic       enable, busy, done;
  logic [7:0] pulses_left;

  int checks = 0;
  int errors = 0;

  counter_enable_gen #(.DIV_WIDTH(4), .LEN_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .div(div), .burst_len(burst_len), .enable(enable), .busy(busy),
    .done(done), .pulses_left(pulses_left)
  );

  always #5 clock = ~clock;

  // downstream 2-bit counter driven by enable
  logic [1:0] c2;
  always @(posedge clock) begin
    if (reset) c2 <= 2'd0;
    else if (enable) c2 <= c2 + 2'd1;
  end

  typedef struct {
    bit       rst, st, sp, hd;
    bit [3:0] dv;
    bit [7:0] bl;
    bit       en, bz, dn;
    bit [7:0] pl;
  } vec_t;

  function automatic vec_t mk(bit rst, bit st, bit sp, bit hd, bit [3:0] dv,
                              bit [7:0] bl, bit en, bit bz, bit dn, bit [7:0] pl);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.hd = hd; v.dv = dv; v.bl = bl;
    v.en = en; v.bz = bz; v.dn = dn; v.pl = pl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then land just after the capturing edge
  task automatic apply(input bit rst, input bit st, input bit sp, input bit hd,
                       input bit [3:0] dv, input bit [7:0] bl);
    @(negedge clock);
    reset = rst; start = st; stop = sp; hold = hd; div = dv; burst_len = bl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit en, input bit bz,
                         input bit dn, input bit [7:0] pl);
    chk({tag, ".enable"}, enable, en);
    chk({tag, ".busy"}, busy, bz);
    chk({tag, ".done"}, done, dn);
    chk({tag, ".pulses_left"}, pulses_left, pl);
  endtask

  // Reference model: a run is a countdown of idle edges before each pulse.
  bit m_busy, m_paused, m_free, m_en, m_dn;
  int m_wait, m_left, m_div;

  task automatic model_step(input bit rst, input bit st, input bit sp,
                            input bit hd, input int dv, input int bl);
    m_en = 0; m_dn = 0;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_left = 0;
    end else if (!m_busy) begin
      if (st && !sp) begin
        m_busy = 1; m_paused = 0; m_div = dv; m_wait = dv;
        m_left = bl; m_free = (bl == 0);
      end
    end else if (sp) begin
      m_busy = 0; m_paused = 0; m_left = 0;
    end else if (hd) begin
      m_paused = 1;
    end else if (m_paused) begin
      m_paused = 0;
      if (m_wait > 0) m_wait--;
    end else if (m_wait == 0) begin
      m_en = 1;
      m_wait = m_div;
      if (!m_free) begin
        m_left--;
        if (m_left == 0) begin
          m_dn = 1; m_busy = 0;
        end
      end
    end else begin
      m_wait--;
    end
  endtask

  vec_t tbl[28];

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; div = '0; burst_len = '0;

    //            rst st sp hd dv bl   en bz dn pl
    tbl[0]  = mk(1, 1, 0, 0, 0, 3,   0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 3,   0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 3,   0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 3,   0, 0, 0, 0);   // start+stop in IDLE
    tbl[4]  = mk(0, 1, 0, 0, 0, 3,   0, 1, 0, 3);   // div=0 burst=3
    tbl[5]  = mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 2);
    tbl[6]  = mk(0, 0, 0, 0, 0, 3,   1, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 3,   1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 3,   0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 4, 2,   0, 1, 0, 2);   // div=4 burst=2 at k
    tbl[10] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 2);
    tbl[11] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 2);
    tbl[12] = mk(0, 1, 0, 0, 4, 9,   0, 1, 0, 2);   // start while busy
    tbl[13] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 2);
    tbl[14] = mk(0, 0, 0, 0, 4, 2,   1, 1, 0, 1);   // k+5
    tbl[15] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 4, 2,   0, 1, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 4, 2,   1, 0, 1, 0);   // k+10
    tbl[20] = mk(0, 0, 0, 0, 4, 2,   0, 0, 0, 0);
    tbl[21] = mk(0, 1, 0, 0, 3, 0,   0, 1, 0, 0);   // free-run start
    tbl[22] = mk(0, 0, 1, 1, 3, 0,   0, 0, 0, 0);   // stop+hold in RUN
    tbl[23] = mk(0, 1, 0, 0, 0, 7,   0, 1, 0, 7);
    tbl[24] = mk(0, 0, 0, 0, 0, 7,   1, 1, 0, 6);
    tbl[25] = mk(0, 0, 0, 0, 0, 7,   1, 1, 0, 5);
    tbl[26] = mk(1, 0, 0, 0, 0, 7,   0, 0, 0, 0);   // reset mid-burst
    tbl[27] = mk(0, 0, 0, 0, 0, 7,   0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].hd, tbl[i].dv, tbl[i].bl);
      chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].bz, tbl[i].dn, tbl[i].pl);
      if (i == 8) chk("vec8.counter2", c2, 2'd3);
    end

    // free-run div=1: enable every second edge until stopped
    apply(0, 1, 0, 0, 1, 0);
    chk_out("fr.start", 0, 1, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      apply(0, 0, 0, 0, 1, 0);
      chk_out($sformatf("fr.e%0d", j), (j % 2 == 0), 1, 0, 0);
    end
    apply(0, 0, 1, 0, 1, 0);
    chk_out("fr.stop", 0, 0, 0, 0);

    // hold for 3 cycles after the first pulse shifts the second pulse by 3
    apply(0, 1, 0, 0, 2, 2);
    chk_out("hd.start", 0, 1, 0, 2);
    for (int j = 1; j <= 2; j++) begin
      apply(0, 0, 0, 0, 2, 2);
      chk_out($sformatf("hd.k%0d", j), 0, 1, 0, 2);
    end
    apply(0, 0, 0, 0, 2, 2);
    chk_out("hd.k3", 1, 1, 0, 1);
    for (int j = 4; j <= 6; j++) begin
      apply(0, 0, 0, 1, 2, 2);
      chk_out($sformatf("hd.k%0d", j), 0, 1, 0, 1);
    end
    for (int j = 7; j <= 8; j++) begin
      apply(0, 0, 0, 0, 2, 2);
      chk_out($sformatf("hd.k%0d", j), 0, 1, 0, 1);
    end
    apply(0, 0, 0, 0, 2, 2);
    chk_out("hd.k9", 1, 0, 1, 0);

    // random phase against the model
    apply(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      bit rst, st, sp, hd;
      bit [3:0] dv;
      bit [7:0] bl;
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 30);
      sp  = ($urandom_range(0, 99) < 4);
      hd  = ($urandom_range(0, 99) < 15);
      dv  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      bl  = 8'($urandom_range(0, 5));
      apply(rst, st, sp, hd, dv, bl);
      model_step(rst, st, sp, hd, dv, bl);
      chk_out($sformatf("rnd%0d", n), m_en, m_busy, m_dn, 8'(m_left));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
